mux_rr_arbiter: RTL and testbench
=================================

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter: MAX_HOLD, 8, maximum GRANT-state cycles per grant; legal range 2..15.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req  input  8  request vector; bit k = requester k wants the shared 8:1 mux channel.
REQ-005 Port: done  input  1  current owner releases the channel; sampled only in GRANT.
REQ-006 Port: sel  output  3  select code for the 8:1 mux; registered.
REQ-007 Port: grant  output  8  one-hot owner indication, all-zero when no owner; registered.
REQ-008 Port: gnt_valid  output  1  high exactly while grant is non-zero.
REQ-009 Port: timeout  output  1  one-cycle pulse on forced release at MAX_HOLD.

Function
REQ-010 The FSM SHALL have three states: IDLE, GRANT and GAP.
REQ-011 IDLE: if req != 0, the arbiter SHALL pick the winner and enter GRANT next cycle. Otherwise it SHALL stay in IDLE.
REQ-012 Winner SHALL be the first set req bit at index ptr, ptr+1, ... ptr+7 (mod 8, wrap 7->0).
REQ-013 On entering GRANT with winner k: sel=k, grant=1<<k, gnt_valid=1, hold_cnt=0, and ptr SHALL be set to (k+1) mod 8.
REQ-014 Latency: grant SHALL appear on the edge after the IDLE cycle in which req was sampled non-zero, which is 1 cycle.
REQ-015 In GRANT, hold_cnt SHALL increment once per cycle. sel and grant SHALL remain constant.
REQ-016 GRANT SHALL exit to GAP when any of these hold: done=1; req[sel]=0; or hold_cnt==MAX_HOLD-1.
REQ-017 Forced release (hold_cnt==MAX_HOLD-1 with done=0 and req[sel]=1) SHALL pulse timeout for exactly the first GAP cycle.
REQ-018 If done=1 or req[sel]=0 in the same cycle as the hold limit, the release is normal and timeout SHALL stay 0.
REQ-019 GAP SHALL last exactly one cycle with grant=0 and gnt_valid=0. sel SHALL hold its last value, which is a break-before-make guarantee.
REQ-020 GAP SHALL always return to IDLE. Re-arbitration then proceeds per REQ-011, so the minimum grant-to-grant spacing is 2 idle cycles.
REQ-021 A requester that releases and still requests SHALL have lowest priority at the next arbitration.
REQ-022 Changes on req during GRANT other than req[sel] SHALL have no effect until the next IDLE.
REQ-023 done asserted in IDLE or GAP SHALL be ignored.
REQ-024 grant SHALL never have more than one bit set, and grant[sel] SHALL equal gnt_valid at all times.

Reset
REQ-025 rst_n low SHALL asynchronously force: state=IDLE, sel=0, grant=0, gnt_valid=0, timeout=0, hold_cnt=0, ptr=0.
REQ-026 Reset mid-GRANT SHALL drop grant immediately, without a GAP cycle and without a timeout pulse.
REQ-027 The first arbitration after reset deassertion SHALL give requester 0 highest priority.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE/GRANT/GAP), N_REQ=8, SEL_W=3 and HOLD_W=4.
REQ-029 One combinational sub-module, rr_pick, SHALL compute the winner index and a found flag from req and ptr. All registers SHALL stay in mux_rr_arbiter.

Verification
REQ-030 Reset release; req=8'h00 for 10 cycles -> gnt_valid=0, sel=0 throughout.
REQ-031 req=8'h81 held, done pulsed 3 cycles after each grant -> grant sequence 8'h01, 8'h80, 8'h01, with a GAP cycle between each pair.
REQ-032 ptr=6 (after a grant to 5); req=8'h22 -> winner sel=5? no: search from 6 wraps to 1, so sel=1, grant=8'h02.
REQ-033 req=8'h04 held, done=0, MAX_HOLD=8 -> grant=8'h04 for exactly 8 cycles; timeout=1 for one cycle; after the GAP and IDLE cycles, grant=8'h04 again.
REQ-034 Same setup with done=1 in the 8th GRANT cycle -> release with timeout=0.
REQ-035 rst_n pulsed low mid-GRANT with grant=8'h10 -> grant=0 asynchronously; after release, req=8'hFF -> grant=8'h01.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_rr_arbiter_pkg: shared sizes and FSM state type for the round-robin mux arbiter
package mux_rr_arbiter_pkg;
  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int HOLD_W = 4;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: first set request bit at or after ptr, wrapping from the top index back to 0
module rr_pick
  import mux_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [SEL_W-1:0] ptr_i,
  output logic [SEL_W-1:0] idx_o,
  output logic             found_o
);
  logic [SEL_W-1:0] k;
  // scan offsets from farthest to nearest so the nearest hit is the one that sticks
  always_comb begin
    idx_o = '0;
    k = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      k = ptr_i + SEL_W'(i);
      if (req_i[k]) idx_o = k;
    end
  end
  assign found_o = |req_i;
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner selection for a shared 8:1 mux with hold limit and break-before-make gap
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             gnt_valid,
  output logic             timeout
);
  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d, ptr_q, ptr_d, pick_idx;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d, pick_found, owner_req, at_limit, release_now;
  rr_pick u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );
  assign owner_req   = req[sel_q];
  assign at_limit    = hold_q == HOLD_W'(MAX_HOLD - 1);
  assign release_now = done | ~owner_req | at_limit;
  // next-state: arbitrate in IDLE, count hold in GRANT, single dead cycle in GAP
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    hold_d    = hold_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: if (pick_found) begin
        state_d = GRANT;
        sel_d   = pick_idx;
        grant_d = N_REQ'(1) << pick_idx;
        hold_d  = '0;
        ptr_d   = pick_idx + SEL_W'(1);
      end
      GRANT: begin
        hold_d = hold_q + HOLD_W'(1);
        if (release_now) begin
          state_d   = GAP;
          grant_d   = '0;
          timeout_d = at_limit & ~done & owner_req;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops any grant immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      grant_q   <= '0;
      hold_q    <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      hold_q    <= hold_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end
  assign sel       = sel_q;
  assign grant     = grant_q;
  assign gnt_valid = |grant_q;
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed scenarios plus random traffic against a behavioural arbiter model
module tb_mux_rr_arbiter;
  localparam int MAX_HOLD = 8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] sel;
  logic [7:0] grant;
  logic       gnt_valid, timeout;
  int n_checks = 0, n_fail = 0;
  int m_owner, m_sel, m_ptr, m_held;
  bit m_gap, m_timeout;
  always #5 clk = ~clk;
  mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .grant     (grant),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_gap = 0; m_timeout = 0;
  endtask
  task automatic model_update();
    if (m_owner >= 0) begin
      m_held++;
      m_timeout = 0;
      if (done || !req[m_owner] || m_held == MAX_HOLD) begin
        m_timeout = !done && req[m_owner] && m_held == MAX_HOLD;
        m_owner = -1;
        m_gap = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
      m_timeout = 0;
    end else begin
      m_timeout = 0;
      for (int i = 0; i < 8; i++)
        if (req[(m_ptr + i) % 8]) begin
          m_owner = (m_ptr + i) % 8;
          break;
        end
      if (m_owner >= 0) begin
        m_sel = m_owner;
        m_ptr = (m_owner + 1) % 8;
        m_held = 0;
      end
    end
  endtask
  task automatic compare_all();
    logic [7:0] g;
    g = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
    check("sel", 32'(sel), 32'(m_sel));
    check("grant", 32'(grant), 32'(g));
    check("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_timeout));
    check("onehot", 32'($onehot0(grant)), 32'd1);
    check("grant_sel", 32'(grant[sel]), 32'(gnt_valid));
  endtask
  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    else model_reset();
    #1;
    compare_all();
  endtask
  initial begin
    logic [7:0] seq_exp [3];
    int cnt;
    seq_exp = '{8'h01, 8'h80, 8'h01};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;
    repeat (10) step();
    req = 8'h81;
    for (int g = 0; g < 3; g++) begin
      step();
      check("seq_grant", 32'(grant), 32'(seq_exp[g]));
      step();
      step();
      done = 1'b1;
      step();
      check("seq_gap", 32'(grant), 32'h0);
      done = 1'b0;
      step();
    end
    req = 8'h00;
    step();
    req = 8'h20;
    step();
    check("pre_wrap_grant", 32'(grant), 32'h20);
    done = 1'b1;
    step();
    done = 1'b0;
    req = 8'h22;
    step();
    step();
    check("wrap_sel", 32'(sel), 32'd1);
    check("wrap_grant", 32'(grant), 32'h02);
    req = 8'h00;
    step();
    step();
    req = 8'h04;
    step();
    cnt = 0;
    for (int i = 0; i < 20 && grant == 8'h04; i++) begin
      cnt++;
      step();
    end
    check("hold_cycles", 32'(cnt), 32'(MAX_HOLD));
    check("timeout_pulse", 32'(timeout), 32'd1);
    step();
    check("timeout_end", 32'(timeout), 32'd0);
    step();
    check("regrant", 32'(grant), 32'h04);
    repeat (MAX_HOLD - 1) step();
    done = 1'b1;
    step();
    check("limit_done_release", 32'(grant), 32'h0);
    check("limit_done_no_timeout", 32'(timeout), 32'd0);
    done = 1'b0;
    req = 8'h00;
    step();
    req = 8'h10;
    step();
    check("pre_reset_grant", 32'(grant), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_grant", 32'(grant), 32'h0);
    check("async_rst_valid", 32'(gnt_valid), 32'd0);
    check("async_rst_sel", 32'(sel), 32'd0);
    check("async_rst_timeout", 32'(timeout), 32'd0);
    model_reset();
    step();
    rst_n = 1'b1;
    req = 8'hFF;
    step();
    check("post_reset_grant", 32'(grant), 32'h01);
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) req = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
      done = ($urandom_range(0, 7) == 0);
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
